// File: rtl/adia_psu_pkg.sv
// adia_psu_pkg
// Shared types and helpers for the multi-phase adiabatic PSU sequencer.
//   state_t    : sequencer FSM state (IDLE, RUN, DRAIN)
//   level_hot  : one bit of the one-hot encoding of a ladder level
//   rel_of     : segment distance of a phase from the current segment
package adia_psu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bit idx of the one-hot vector that selects ladder level "level".
    function automatic logic level_hot(input int level, input int idx);
        return (level == idx);
    endfunction

    // (s - k) mod phases, kept non-negative.
    function automatic int rel_of(input int s, input int k, input int phases);
        return (s + phases - k) % phases;
    endfunction

endpackage

// File: rtl/adia_psu_phase_ctl.sv
// adia_psu_phase_ctl
// One tank ladder: turns the (next) segment distance, step index and
// activity of a phase into a registered one-hot switch select.
// Optional build macro: DEADTIME_EN (break-before-make, one all-zero
// cycle in front of every level change).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   rel       : (s - k) mod PHASES for the coming cycle
//   t         : step index for the coming cycle
//   active    : phase activity for the coming cycle
//   tick      : levels may change on this edge
//   ctl       : one-hot level select, STEPS+1 bits
//   eval_en   : phase is in a held-high segment
module adia_psu_phase_ctl
    import adia_psu_pkg::*;
#(
    parameter int STEPS  = 8,
    parameter int PHASES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(PHASES)-1:0]   rel,
    input  logic [$clog2(STEPS)-1:0]    t,
    input  logic                        active,
    input  logic                        tick,
    output logic [STEPS:0]              ctl,
    output logic                        eval_en
);

    localparam int LW = $clog2(STEPS + 1);

    int            lvl_i;
    int            t_i;
    int            rel_i;
    logic          eval_nxt;
    logic [LW-1:0] lvl_nxt;
    logic [LW-1:0] lvl_q;
    logic [STEPS:0] oh_nxt;
    logic [STEPS:0] oh_q;
    logic          dt_gap;

    always_comb begin
        t_i      = 32'(t);
        rel_i    = 32'(rel);
        lvl_i    = 0;
        eval_nxt = 1'b0;
        if (active) begin
            if (rel_i == 0) begin
                lvl_i = t_i + 1;
            end else if (rel_i < PHASES / 2) begin
                lvl_i    = STEPS;
                eval_nxt = 1'b1;
            end else if (rel_i == PHASES / 2) begin
                lvl_i = STEPS - 1 - t_i;
            end
        end
    end

    assign lvl_nxt = LW'(lvl_i);

    always_comb begin
        oh_nxt = '0;
        oh_q   = '0;
        for (int i = 0; i <= STEPS; i++) begin
            oh_nxt[i] = level_hot(lvl_i, i);
            oh_q[i]   = level_hot(32'(lvl_q), i);
        end
    end

`ifdef DEADTIME_EN
    // Open every switch for one cycle when the level is about to move;
    // the held level is restored from lvl_q on the following cycle.
    assign dt_gap = (lvl_nxt != lvl_q);
`else
    assign dt_gap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q   <= '0;
            ctl     <= {{STEPS{1'b0}}, 1'b1};
            eval_en <= 1'b0;
        end else if (tick) begin
            lvl_q   <= lvl_nxt;
            eval_en <= eval_nxt;
            ctl     <= dt_gap ? '0 : oh_nxt;
        end else begin
            ctl <= oh_q;
        end
    end

endmodule

// File: rtl/adia_psu_seq_multi.sv
// adia_psu_seq_multi
// Parametrised multi-phase adiabatic PSU sequencer with run/drain handshake.
// Optional build macro: DEADTIME_EN (break-before-make on every ladder,
// effective dwell forced to at least two cycles).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   run          : 1 = run, 0 = drain and stop
//   step_div     : step dwell minus 1 (latched at start and period wrap)
//   ctl          : per-phase one-hot level select, phase k at k*(STEPS+1)
//   eval_en      : per-phase held-high indicator
//   busy         : sequencer not idle
//   period_tick  : pulse in the last step-tick cycle of a period
//
// state | meaning
// IDLE  | counters held at 0, all phases inactive at level 0
// RUN   | counters run, phases join at their own segment start
// DRAIN | counters run, phases drop out after their ramp-down
module adia_psu_seq_multi
    import adia_psu_pkg::*;
#(
    parameter int STEPS  = 8,
    parameter int PHASES = 4,
    parameter int DIV_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic [DIV_W-1:0]            step_div,
    output logic [PHASES*(STEPS+1)-1:0] ctl,
    output logic [PHASES-1:0]           eval_en,
    output logic                        busy,
    output logic                        period_tick
);

    localparam int TW = $clog2(STEPS);
    localparam int SW = $clog2(PHASES);

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_cnt_nxt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_q_nxt;
    logic [DIV_W-1:0]  eff_div;
    logic [DIV_W-1:0]  eff_div_nxt;
    logic [TW-1:0]     t;
    logic [TW-1:0]     t_nxt;
    logic [SW-1:0]     s;
    logic [SW-1:0]     s_nxt;
    logic [PHASES-1:0] active;
    logic [PHASES-1:0] active_nxt;
    logic [SW-1:0]     rel_nxt [PHASES];
    logic              tick;
    logic              last_step;
    logic              step_edge;

`ifdef DEADTIME_EN
    assign eff_div     = (div_q == '0) ? DIV_W'(1) : div_q;
    assign eff_div_nxt = (div_q_nxt == '0) ? DIV_W'(1) : div_q_nxt;
`else
    assign eff_div     = div_q;
    assign eff_div_nxt = div_q_nxt;
`endif

    assign tick      = (state != IDLE) && (div_cnt == eff_div);
    assign last_step = tick && (t == TW'(STEPS - 1));
    // Ladders only move on a step tick or on the start edge out of IDLE.
    assign step_edge = tick || ((state == IDLE) && run);

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        div_q_nxt   = div_q;
        t_nxt       = t;
        s_nxt       = s;
        active_nxt  = active;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt     = RUN;
                    div_q_nxt     = step_div;
                    active_nxt[0] = 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    div_cnt_nxt = '0;
                    if (t == TW'(STEPS - 1)) begin
                        t_nxt = '0;
                        if (s == SW'(PHASES - 1)) begin
                            s_nxt     = '0;
                            div_q_nxt = step_div;
                        end else begin
                            s_nxt = s + SW'(1);
                        end
                    end else begin
                        t_nxt = t + TW'(1);
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end

                if (state == DRAIN) begin
                    // A phase retires only once its ramp-down has reached level 0.
                    for (int k = 0; k < PHASES; k++) begin
                        if (last_step && (rel_of(32'(s), k, PHASES) == PHASES / 2)) begin
                            active_nxt[k] = 1'b0;
                        end
                    end
                    if (run) begin
                        state_nxt = RUN;
                    end else if (active == '0) begin
                        state_nxt   = IDLE;
                        div_cnt_nxt = '0;
                        t_nxt       = '0;
                        s_nxt       = '0;
                    end
                end else if (!run) begin
                    state_nxt = DRAIN;
                end

                // Phases only join at the start of their own ramp-up segment.
                if ((state_nxt == RUN) && tick && (t_nxt == '0)) begin
                    active_nxt[s_nxt] = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < PHASES; k++) begin
            rel_nxt[k] = SW'(rel_of(32'(s_nxt), k, PHASES));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            div_q       <= '0;
            t           <= '0;
            s           <= '0;
            active      <= '0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_cnt_nxt;
            div_q       <= div_q_nxt;
            t           <= t_nxt;
            s           <= s_nxt;
            active      <= active_nxt;
            busy        <= (state_nxt != IDLE);
            period_tick <= (state_nxt != IDLE) && (s_nxt == SW'(PHASES - 1)) &&
                           (t_nxt == TW'(STEPS - 1)) && (div_cnt_nxt == eff_div_nxt);
        end
    end

    for (genvar k = 0; k < PHASES; k++) begin : g_phase
        adia_psu_phase_ctl #(
            .STEPS  (STEPS),
            .PHASES (PHASES)
        ) u_phase (
            .clk     (clk),
            .rst     (rst),
            .rel     (rel_nxt[k]),
            .t       (t_nxt),
            .active  (active_nxt[k]),
            .tick    (step_edge),
            .ctl     (ctl[k*(STEPS+1) +: STEPS+1]),
            .eval_en (eval_en[k])
        );
    end

endmodule

// File: tb/tb_adia_psu_seq_multi.sv
module tb_adia_psu_seq_multi;

    localparam int S  = 8;
    localparam int P  = 4;
    localparam int DW = 4;
    localparam int CW = P * (S + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [DW-1:0] step_div;
    logic [CW-1:0] ctl;
    logic [P-1:0]  eval_en;
    logic          busy;
    logic          period_tick;

    int checks = 0;
    int errors = 0;

    adia_psu_seq_multi #(.STEPS(S), .PHASES(P), .DIV_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step_div    (step_div),
        .ctl         (ctl),
        .eval_en     (eval_en),
        .busy        (busy),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    // Reference model: one free-running cycle index within the period;
    // step, segment and step index are derived from it by division.
    int          m_mode;   // 0 idle, 1 run, 2 drain
    int          m_n;
    int          m_div;
    bit [P-1:0]  m_act;
    int          m_prev [P];
    logic [CW-1:0] e_ctl;
    logic [P-1:0]  e_eval;
    logic          e_busy;
    logic          e_pt;
    logic [CW-1:0] idle_ctl;

    function automatic int eff(input int d);
`ifdef DEADTIME_EN
        return (d == 0) ? 1 : d;
`else
        return d;
`endif
    endfunction

    function automatic int period_len(input int d);
        return P * S * (eff(d) + 1);
    endfunction

    task automatic model_outputs();
        int d, step, s, t, rel, lvl;
        d    = eff(m_div);
        step = m_n / (d + 1);
        s    = step / S;
        t    = step % S;
        e_ctl  = '0;
        e_eval = '0;
        for (int k = 0; k < P; k++) begin
            rel = (s - k + P) % P;
            lvl = 0;
            if (m_act[k]) begin
                if (rel == 0) lvl = t + 1;
                else if (rel < P / 2) begin lvl = S; e_eval[k] = 1'b1; end
                else if (rel == P / 2) lvl = S - 1 - t;
            end
`ifdef DEADTIME_EN
            if (lvl == m_prev[k]) e_ctl[k*(S+1) + lvl] = 1'b1;
`else
            e_ctl[k*(S+1) + lvl] = 1'b1;
`endif
            m_prev[k] = lvl;
        end
        e_busy = (m_mode != 0);
        e_pt   = (m_mode != 0) && (m_n == period_len(m_div) - 1);
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_div = 0; m_act = '0;
        for (int k = 0; k < P; k++) m_prev[k] = 0;
        model_outputs();
    endtask

    task automatic model_step(input bit r, input int sd);
        int d, step, s, t, n_new;
        bit tick;
        bit [P-1:0] act_old;
        if (m_mode == 0) begin
            if (r) begin
                m_mode = 1; m_div = sd; m_n = 0; m_act = '0; m_act[0] = 1'b1;
            end
        end else begin
            d    = eff(m_div);
            step = m_n / (d + 1);
            s    = step / S;
            t    = step % S;
            tick = ((m_n % (d + 1)) == d);
            act_old = m_act;
            if (m_mode == 2)
                for (int k = 0; k < P; k++)
                    if (tick && t == S - 1 && ((s - k + P) % P) == P / 2) m_act[k] = 1'b0;
            n_new = m_n + 1;
            if (n_new == period_len(m_div)) begin n_new = 0; m_div = sd; end
            if (m_mode == 1) begin
                if (!r) m_mode = 2;
            end else if (r) begin
                m_mode = 1;
            end else if (act_old == '0) begin
                m_mode = 0; n_new = 0;
            end
            m_n = n_new;
            if (m_mode == 1)
                for (int k = 0; k < P; k++)
                    if (m_n == k * S * (eff(m_div) + 1)) m_act[k] = 1'b1;
        end
        model_outputs();
    endtask

    task automatic advance(input bit r, input int sd);
        run      = r;
        step_div = DW'(sd);
        @(posedge clk);
        model_step(r, sd);
        #1;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; step_div = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step_div = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ctl, eval_en, busy, period_tick} !== {idle_ctl, {P{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset ctl=%h ev=%b busy=%b pt=%b required ctl=%h ev=0 busy=0 pt=0",
                     ctl, eval_en, busy, period_tick, idle_ctl);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            advance(1'b0, 0);
            checks++;
            if ({ctl, eval_en, busy, period_tick} !== {e_ctl, e_eval, e_busy, e_pt}) begin
                errors++;
                $display("FAIL idle_hold c=%0d got %h/%b/%b/%b required %h/%b/%b/%b",
                         c, ctl, eval_en, busy, period_tick, e_ctl, e_eval, e_busy, e_pt);
            end
        end
    endtask

    task automatic test_nominal();
        for (int c = 0; c < 40; c++) begin
            advance(1'b1, 0);
            checks++;
            if ({ctl, eval_en, busy, period_tick} !== {e_ctl, e_eval, e_busy, e_pt}) begin
                errors++;
                $display("FAIL nominal c=%0d got %h/%b/%b/%b required %h/%b/%b/%b",
                         c, ctl, eval_en, busy, period_tick, e_ctl, e_eval, e_busy, e_pt);
            end
`ifndef DEADTIME_EN
            if (c == 7 || c == 23 || c == 16 || c == 31 || c == 12) begin
                checks++;
                if ((c == 7  && ctl[0 +: S+1] !== 9'h100) ||
                    (c == 12 && eval_en[0] !== 1'b1) ||
                    (c == 16 && ctl[2*(S+1) +: S+1] !== 9'h002) ||
                    (c == 23 && ctl[0 +: S+1] !== 9'h001) ||
                    (c == 31 && period_tick !== 1'b1)) begin
                    errors++;
                    $display("FAIL nominal_point c=%0d ctl=%h ev=%b pt=%b", c, ctl, eval_en, period_tick);
                end
            end
`endif
        end
    endtask

    task automatic test_drain();
        for (int c = 40; c < 120; c++) begin
            advance(1'b0, 0);
            checks++;
            if ({ctl, eval_en, busy, period_tick} !== {e_ctl, e_eval, e_busy, e_pt}) begin
                errors++;
                $display("FAIL drain c=%0d got %h/%b/%b/%b required %h/%b/%b/%b",
                         c, ctl, eval_en, busy, period_tick, e_ctl, e_eval, e_busy, e_pt);
            end
        end
        checks++;
        if ({ctl, busy} !== {idle_ctl, 1'b0}) begin
            errors++;
            $display("FAIL drain_end ctl=%h busy=%b required ctl=%h busy=0", ctl, busy, idle_ctl);
        end
    endtask

    task automatic test_dwell_change();
        int pt1, pt2, first, second, sd;
        hard_reset();
        pt1 = -1; pt2 = -1;
        first  = period_len(0) - 1;
        second = first + period_len(2);
        for (int c = 0; c < second + 8; c++) begin
            sd = (c < 10) ? 0 : 2;
            advance(1'b1, sd);
            checks++;
            if ({ctl, eval_en, busy, period_tick} !== {e_ctl, e_eval, e_busy, e_pt}) begin
                errors++;
                $display("FAIL dwell c=%0d got %h/%b/%b/%b required %h/%b/%b/%b",
                         c, ctl, eval_en, busy, period_tick, e_ctl, e_eval, e_busy, e_pt);
            end
            if (period_tick === 1'b1) begin
                if (pt1 < 0) pt1 = c;
                else if (pt2 < 0) pt2 = c;
            end
        end
        checks++;
        if (pt1 != first || pt2 != second) begin
            errors++;
            $display("FAIL dwell_period ticks at %0d,%0d required %0d,%0d", pt1, pt2, first, second);
        end
    endtask

    task automatic test_reset_mid_ramp();
        hard_reset();
        for (int c = 0; c <= 5; c++) advance(1'b1, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ctl, eval_en, busy, period_tick} !== {idle_ctl, {P{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset ctl=%h ev=%b busy=%b pt=%b required ctl=%h all else 0",
                     ctl, eval_en, busy, period_tick, idle_ctl);
        end
        model_reset();
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            advance(1'b1, 0);
            checks++;
            if ({ctl, eval_en, busy, period_tick} !== {e_ctl, e_eval, e_busy, e_pt}) begin
                errors++;
                $display("FAIL restart c=%0d got %h/%b/%b/%b required %h/%b/%b/%b",
                         c, ctl, eval_en, busy, period_tick, e_ctl, e_eval, e_busy, e_pt);
            end
        end
    endtask

    task automatic test_random();
        bit r;
        int sd;
        hard_reset();
        r = 1'b1; sd = 1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) r = ~r;
            if ($urandom_range(0, 29) == 0) sd = $urandom_range(0, 3);
            advance(r, sd);
            checks++;
            if ({ctl, eval_en, busy, period_tick} !== {e_ctl, e_eval, e_busy, e_pt}) begin
                errors++;
                $display("FAIL random c=%0d got %h/%b/%b/%b required %h/%b/%b/%b",
                         c, ctl, eval_en, busy, period_tick, e_ctl, e_eval, e_busy, e_pt);
            end
            for (int k = 0; k < P; k++) begin
                checks++;
                if ($countones(ctl[k*(S+1) +: S+1]) > 1) begin
                    errors++;
                    $display("FAIL two_hot c=%0d phase=%0d ctl=%h required at most one bit",
                             c, k, ctl[k*(S+1) +: S+1]);
                end
            end
        end
    endtask

    initial begin
        idle_ctl = '0;
        for (int k = 0; k < P; k++) idle_ctl[k*(S+1)] = 1'b1;
        rst = 1'b1; run = 1'b0; step_div = '0;
        test_reset();
        test_nominal();
        test_drain();
        test_dwell_change();
        test_reset_mid_ramp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
